// File: rtl/forney_eval_pipe.sv
// Two-stage Forney error-value evaluator, y = num*phase*inv(den) over GF(2^10).
// Define FORNEY_CW_STATS_EN to add per-codeword error count and fail outputs.
module forney_eval_pipe #(
   parameter int    W        = 10,
   parameter int    POS_W    = 10,
   parameter int    LANES    = 2,
   parameter string MEM_PATH = "../rtl/gf1024_inv_table.mem"
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_vld_i,
   output logic                   in_rdy_o,
   input  logic [LANES-1:0]       in_lane_en_i,
   input  logic                   in_last_i,
   input  logic [LANES*POS_W-1:0] in_pos_i,
   input  logic [LANES*W-1:0]     in_num_i,
   input  logic [LANES*W-1:0]     in_den_i,
   input  logic [LANES*W-1:0]     in_phase_i,
   output logic                   out_vld_o,
   input  logic                   out_rdy_i,
   output logic [LANES-1:0]       out_lane_en_o,
   output logic                   out_last_o,
   output logic [LANES*POS_W-1:0] out_pos_o,
   output logic [LANES*W-1:0]     out_y_o,
   output logic [LANES-1:0]       out_den_zero_o
`ifdef FORNEY_CW_STATS_EN
   ,
   output logic [$clog2(LANES*64+1)-1:0] out_err_cnt_o,
   output logic                          out_cw_fail_o
`endif
);

   // Inverse is a^(2^W-2), the same mapping as the MEM_PATH image.
   if (MEM_PATH == "") begin : g_no_img
   end

   localparam logic [W-1:0] RED = W'(11'h409);

   function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W-1:0] p;
      p = '0;
      for (int i = W - 1; i >= 0; i--) begin
         p = {p[W-2:0], 1'b0} ^ (p[W-1] ? RED : '0);
         if (b[i]) p = p ^ a;
      end
      return p;
   endfunction

   function automatic logic [W-1:0] gf_inv(input logic [W-1:0] a);
      logic [W-1:0] s;
      logic [W-1:0] r;
      s = a;
      r = W'(1);
      for (int i = 1; i < W; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   logic                   a_vld_q;
   logic [LANES*W-1:0]     a_pre_q, a_inv_q;
   logic [LANES*POS_W-1:0] a_pos_q;
   logic [LANES-1:0]       a_en_q;
   logic                   a_last_q;

   logic                   b_vld_q;
   logic [LANES*W-1:0]     b_y_q;
   logic [LANES*POS_W-1:0] b_pos_q;
   logic [LANES-1:0]       b_en_q, b_dz_q;
   logic                   b_last_q;

   logic [LANES*W-1:0]     pre_d, inv_d, y_d;
   logic [LANES-1:0]       dz_d;
   logic                   b_rdy, in_fire, b_fire;

   assign b_rdy    = !b_vld_q | out_rdy_i;
   assign in_rdy_o = !a_vld_q | b_rdy;
   assign in_fire  = in_vld_i & in_rdy_o;
   assign b_fire   = a_vld_q & b_rdy;

   // Stage A arithmetic: num*phase product and den inverse per lane.
   always_comb begin
      pre_d = '0;
      inv_d = '0;
      for (int k = 0; k < LANES; k++) begin
         pre_d[k*W +: W] = gf_mul(in_num_i[k*W +: W], in_phase_i[k*W +: W]);
         inv_d[k*W +: W] = gf_inv(in_den_i[k*W +: W]);
      end
   end

   // Stage B arithmetic: y = pre*inv, zeroed for empty lanes or den==0.
   always_comb begin
      y_d  = '0;
      dz_d = '0;
      for (int k = 0; k < LANES; k++) begin
         dz_d[k] = a_en_q[k] & (a_inv_q[k*W +: W] == '0);
         if (a_en_q[k] && a_inv_q[k*W +: W] != '0)
            y_d[k*W +: W] = gf_mul(a_pre_q[k*W +: W], a_inv_q[k*W +: W]);
      end
   end

   // Stage A register: load on accept, empty when drained into stage B.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_vld_q  <= 1'b0;
         a_pre_q  <= '0;
         a_inv_q  <= '0;
         a_pos_q  <= '0;
         a_en_q   <= '0;
         a_last_q <= 1'b0;
      end else if (in_fire) begin
         a_vld_q  <= 1'b1;
         a_pre_q  <= pre_d;
         a_inv_q  <= inv_d;
         a_pos_q  <= in_pos_i;
         a_en_q   <= in_lane_en_i;
         a_last_q <= in_last_i;
      end else if (b_fire) begin
         a_vld_q  <= 1'b0;
      end
   end

   // Stage B register: output beat, held while downstream stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         b_vld_q  <= 1'b0;
         b_y_q    <= '0;
         b_pos_q  <= '0;
         b_en_q   <= '0;
         b_dz_q   <= '0;
         b_last_q <= 1'b0;
      end else if (b_fire) begin
         b_vld_q  <= 1'b1;
         b_y_q    <= y_d;
         b_pos_q  <= a_pos_q;
         b_en_q   <= a_en_q;
         b_dz_q   <= dz_d;
         b_last_q <= a_last_q;
      end else if (out_rdy_i) begin
         b_vld_q  <= 1'b0;
      end
   end

   assign out_vld_o      = b_vld_q;
   assign out_y_o        = b_y_q;
   assign out_pos_o      = b_pos_q;
   assign out_lane_en_o  = b_en_q;
   assign out_den_zero_o = b_dz_q;
   assign out_last_o     = b_last_q;

`ifdef FORNEY_CW_STATS_EN
   localparam int CW = $clog2(LANES*64+1);

   function automatic logic [CW-1:0] popc(input logic [LANES-1:0] m);
      logic [CW-1:0] c;
      c = '0;
      for (int k = 0; k < LANES; k++) c = c + CW'(m[k]);
      return c;
   endfunction

   logic [CW-1:0] acc_q, cnt_q, sum_sat;
   logic [CW:0]   sum_raw;
   logic          acc_fail_q, fail_q, fail_d;

   assign sum_raw = {1'b0, acc_q} + {1'b0, popc(a_en_q)};
   assign sum_sat = sum_raw[CW] ? '1 : sum_raw[CW-1:0];
   assign fail_d  = acc_fail_q | (|dz_d);

   // Codeword accumulators advance with each beat entering the output stage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q      <= '0;
         acc_fail_q <= 1'b0;
         cnt_q      <= '0;
         fail_q     <= 1'b0;
      end else if (b_fire) begin
         cnt_q      <= sum_sat;
         fail_q     <= fail_d;
         acc_q      <= a_last_q ? '0 : sum_sat;
         acc_fail_q <= a_last_q ? 1'b0 : fail_d;
      end
   end

   assign out_err_cnt_o = cnt_q;
   assign out_cw_fail_o = fail_q;
`endif

endmodule

// File: tb/tb_forney_eval_pipe.sv
// Directed bench for forney_eval_pipe (LANES=2, W=10).
// Covers latency, den==0, empty lanes, streaming, stalls, reset, stats.
module tb_forney_eval_pipe;
   localparam int W = 10;
   localparam int POS_W = 10;
   localparam int LANES = 2;

   logic                   clk, rst;
   logic                   in_vld, in_rdy, in_last;
   logic [LANES-1:0]       in_en;
   logic [LANES*POS_W-1:0] in_pos;
   logic [LANES*W-1:0]     in_num, in_den, in_ph;
   logic                   out_vld, out_rdy, out_last;
   logic [LANES-1:0]       out_en, out_dz;
   logic [LANES*POS_W-1:0] out_pos;
   logic [LANES*W-1:0]     out_y;
`ifdef FORNEY_CW_STATS_EN
   logic [$clog2(LANES*64+1)-1:0] err_cnt;
   logic                          cw_fail;
`endif

   forney_eval_pipe #(.W(W), .POS_W(POS_W), .LANES(LANES)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .in_vld_i       (in_vld),
      .in_rdy_o       (in_rdy),
      .in_lane_en_i   (in_en),
      .in_last_i      (in_last),
      .in_pos_i       (in_pos),
      .in_num_i       (in_num),
      .in_den_i       (in_den),
      .in_phase_i     (in_ph),
      .out_vld_o      (out_vld),
      .out_rdy_i      (out_rdy),
      .out_lane_en_o  (out_en),
      .out_last_o     (out_last),
      .out_pos_o      (out_pos),
      .out_y_o        (out_y),
      .out_den_zero_o (out_dz)
`ifdef FORNEY_CW_STATS_EN
      ,
      .out_err_cnt_o  (err_cnt),
      .out_cw_fail_o  (cw_fail)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] en, input logic last,
                        input logic [9:0] p0, input logic [9:0] p1,
                        input logic [9:0] n0, input logic [9:0] n1,
                        input logic [9:0] d0, input logic [9:0] d1,
                        input logic [9:0] h0, input logic [9:0] h1);
      in_vld  = 1'b1;
      in_en   = en;
      in_last = last;
      in_pos  = {p1, p0};
      in_num  = {n1, n0};
      in_den  = {d1, d0};
      in_ph   = {h1, h0};
   endtask

   logic pat [6];
   int   snd, rcv, cyc, infl;
   logic pv;
   logic [19:0] hy, hp;

   initial begin
      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
      in_en = '0; in_last = 1'b0; in_pos = '0;
      in_num = '0; in_den = '0; in_ph = '0;
      repeat (2) step();
      chk("rst_vld", out_vld, 0);
      chk("rst_y", out_y, 0);
      chk("rst_dz", out_dz, 0);
      chk("rst_pos", out_pos, 0);
      rst = 1'b0;
      #1;
      chk("rst_rdy", in_rdy, 1);

      // basic product, 2-cycle latency
      drive(2'b11, 0, 3, 7, 1, 2, 1, 1, 1, 3);
      step(); in_vld = 1'b0;
      chk("t1_lat", out_vld, 0);
      step();
      chk("t1_vld", out_vld, 1);
      chk("t1_y", out_y, {10'h006, 10'h001});
      chk("t1_dz", out_dz, 2'b00);
      chk("t1_pos", out_pos, {10'd7, 10'd3});
      chk("t1_en", out_en, 2'b11);
      step();
      chk("t1_drain", out_vld, 0);

      // inverse of x and den==0 lane
      drive(2'b11, 0, 1, 2, 1, 5, 2, 0, 1, 1);
      step(); in_vld = 1'b0; step();
      chk("t2_y", out_y, {10'h000, 10'h204});
      chk("t2_dz", out_dz, 2'b10);

      // lane 1 disabled
      drive(2'b01, 0, 4, 5, 3, 3, 1, 1, 1, 1);
      step(); in_vld = 1'b0; step();
      chk("t3_y", out_y, {10'h000, 10'h003});
      chk("t3_dz", out_dz, 2'b00);
      chk("t3_en", out_en, 2'b01);

      // empty beat still closes the codeword
      drive(2'b00, 1, 6, 8, 5, 5, 0, 0, 1, 1);
      step(); in_vld = 1'b0; step();
      chk("t4_vld", out_vld, 1);
      chk("t4_y", out_y, 0);
      chk("t4_dz", out_dz, 0);
      chk("t4_last", out_last, 1);
      step();

      // 8 back-to-back beats
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) drive(2'b11, 0, 10'(i), 10'(i + 16), 10'(i + 1),
                          10'(i + 1), 1, 1, 1, 2);
         else in_vld = 1'b0;
         #1;
         if (i < 8) chk("s8_rdy", in_rdy, 1);
         @(posedge clk); #1;
         if (i >= 1) begin
            chk("s8_vld", out_vld, 1);
            chk("s8_pos", out_pos, {10'(i + 15), 10'(i - 1)});
            chk("s8_y", out_y, {10'(i * 2), 10'(i)});
         end
      end
      step();
      chk("s8_drain", out_vld, 0);

      // 6 beats under toggling out_rdy
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      snd = 0; rcv = 0; cyc = 0; infl = 0; pv = 1'b0; hy = '0; hp = '0;
      while (rcv < 6 && cyc < 60) begin
         out_rdy = pat[cyc % 6];
         if (snd < 6) drive(2'b11, 0, 10'(snd + 40), 10'(snd + 32),
                            10'(snd + 3), 10'(snd + 1), 1, 1, 1, 1);
         else in_vld = 1'b0;
         #1;
         chk("st_rdy", in_rdy, !(infl == 2 && !out_rdy));
         if (pv) begin
            chk("st_hold_vld", out_vld, 1);
            chk("st_hold_y", out_y, hy);
            chk("st_hold_pos", out_pos, hp);
         end
         pv = out_vld && !out_rdy;
         hy = out_y;
         hp = out_pos;
         if (out_vld && out_rdy) begin
            chk("st_y", out_y, {10'(rcv + 1), 10'(rcv + 3)});
            chk("st_pos", out_pos, {10'(rcv + 32), 10'(rcv + 40)});
            rcv++;
            infl--;
         end
         if (in_vld && in_rdy) begin
            snd++;
            infl++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("st_done", rcv, 6);
      in_vld = 1'b0; out_rdy = 1'b1;
      step(); step();
      chk("st_nodup", out_vld, 0);

      // reset with two beats in flight
      drive(2'b11, 0, 11, 12, 7, 7, 1, 1, 1, 1);
      step();
      drive(2'b11, 0, 13, 14, 9, 9, 1, 1, 1, 1);
      step();
      chk("r_full", out_vld, 1);
      rst = 1'b1; in_vld = 1'b0;
      step();
      chk("r_vld", out_vld, 0);
      chk("r_y", out_y, 0);
      rst = 1'b0;
      #1;
      chk("r_rdy", in_rdy, 1);
      step();
      chk("r_gone1", out_vld, 0);
      step();
      chk("r_gone2", out_vld, 0);
      drive(2'b11, 1, 9, 10, 1, 3, 2, 1, 1, 1);
      step(); in_vld = 1'b0;
      chk("r_lat", out_vld, 0);
      step();
      chk("r_new_vld", out_vld, 1);
      chk("r_new_y", out_y, {10'h003, 10'h204});
      chk("r_new_last", out_last, 1);
      step();

`ifdef FORNEY_CW_STATS_EN
      drive(2'b11, 0, 1, 2, 1, 1, 1, 1, 1, 1);
      step();
      drive(2'b01, 0, 3, 4, 1, 1, 0, 1, 1, 1);
      step();
      drive(2'b10, 1, 5, 6, 1, 1, 1, 1, 1, 1);
      step(); in_vld = 1'b0;
      step();
      chk("cw_last", out_last, 1);
      chk("cw_cnt", err_cnt, 4);
      chk("cw_fail", cw_fail, 1);
      drive(2'b00, 1, 0, 0, 1, 1, 1, 1, 1, 1);
      step(); in_vld = 1'b0; step();
      chk("cw2_last", out_last, 1);
      chk("cw2_cnt", err_cnt, 0);
      chk("cw2_fail", cw_fail, 0);
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
